router_fsm: RTL and testbench

ROUTER_FSM -- requirements
Module: router_fsm

---
 rtl/router_fsm_if.sv | 44 ++++
 rtl/router_fsm.sv | 103 ++++++++++
 tb/tb_router_fsm.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/router_fsm_if.sv
// Handshake and status bundle between the router source/FIFO side and the
// packet-routing FSM. state_dbg exposes the FSM's current state for observation.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;
  logic       busy;
  logic [1:0] addr_out;
  logic [2:0] state_dbg;

  // Valid/ready semantics: the source presents a byte while pkt_valid is high
  // and must hold it unchanged for every cycle busy is high; a byte is taken
  // on each rising edge where pkt_valid=1 and busy=0.
  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1,
           fifo_empty_2, soft_reset_0, soft_reset_1, soft_reset_2,
           parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, busy, addr_out, state_dbg
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1,
           fifo_empty_2, soft_reset_0, soft_reset_1, soft_reset_2,
           parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, busy, addr_out, state_dbg
  );
endinterface

// File: rtl/router_fsm.sv
// Packet-routing control FSM: decodes the header address, sequences payload
// and parity loads into the selected output FIFO, and stalls on FIFO full.
module router_fsm (
  input  logic         clock,
  input  logic         resetn,
  router_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       empty_din;
  logic       empty_addr;
  logic       soft_sel;
  logic       hdr_ok;

  assign hdr_ok = bus.pkt_valid && (bus.data_in != 2'b11);

  always_comb begin
    empty_din  = 1'b0;
    empty_addr = 1'b0;
    soft_sel   = 1'b0;
    case (bus.data_in)
      2'b00:   empty_din = bus.fifo_empty_0;
      2'b01:   empty_din = bus.fifo_empty_1;
      2'b10:   empty_din = bus.fifo_empty_2;
      default: empty_din = 1'b0;
    endcase
    case (bus.addr_out)
      2'b00: begin empty_addr = bus.fifo_empty_0; soft_sel = bus.soft_reset_0; end
      2'b01: begin empty_addr = bus.fifo_empty_1; soft_sel = bus.soft_reset_1; end
      2'b10: begin empty_addr = bus.fifo_empty_2; soft_sel = bus.soft_reset_2; end
      default: begin empty_addr = 1'b0; soft_sel = 1'b0; end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= DECODE_ADDRESS;
      bus.addr_out <= 2'b00;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && hdr_ok)
        bus.addr_out <= bus.data_in;
    end
  end

  always_comb begin
    next_state = state;
    // Soft reset of the port owning the current packet aborts it from anywhere.
    if (state != DECODE_ADDRESS && soft_sel) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS:
          if (hdr_ok) next_state = empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:
          if (empty_addr) next_state = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:
          next_state = LOAD_DATA;
        LOAD_DATA:
          if (bus.fifo_full)       next_state = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) next_state = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!bus.fifo_full) next_state = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (bus.parity_done)        next_state = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) next_state = LOAD_PARITY;
          else                        next_state = LOAD_DATA;
        LOAD_PARITY:
          next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          next_state = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:
          next_state = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    bus.detect_add    = (state == DECODE_ADDRESS);
    bus.lfd_state     = (state == LOAD_FIRST_DATA);
    bus.ld_state      = (state == LOAD_DATA);
    bus.full_state    = (state == FIFO_FULL_STATE);
    bus.laf_state     = (state == LOAD_AFTER_FULL);
    bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                        (state == LOAD_AFTER_FULL);
    bus.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    bus.state_dbg     = state;
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios followed by random traffic,
// checked cycle by cycle against a state-table reference model.
module tb_router_fsm;

  logic clk;
  logic resetn;
  int   checks;
  int   fails;
  int   cyc;

  router_fsm_if bus ();

  router_fsm dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {M_DA, M_LFD, M_LD, M_FF, M_LAF, M_LP, M_CPE, M_WTE} mstate_t;

  mstate_t    m_st;
  int         m_addr;
  logic [9:0] exp_q[$];

  // Output flags per state: {detect,lfd,ld,laf,full,write,rst_int,busy}
  function automatic logic [7:0] flags_of(mstate_t s);
    case (s)
      M_DA:    return 8'b1000_0000;
      M_LFD:   return 8'b0100_0001;
      M_LD:    return 8'b0010_0100;
      M_LAF:   return 8'b0001_0101;
      M_FF:    return 8'b0000_1001;
      M_LP:    return 8'b0000_0101;
      M_CPE:   return 8'b0000_0011;
      default: return 8'b0000_0001;
    endcase
  endfunction

  task automatic model_step();
    logic empty [3];
    logic sr    [3];
    int   din;
    empty[0] = bus.fifo_empty_0; empty[1] = bus.fifo_empty_1; empty[2] = bus.fifo_empty_2;
    sr[0]    = bus.soft_reset_0; sr[1]    = bus.soft_reset_1; sr[2]    = bus.soft_reset_2;
    din      = int'(bus.data_in);
    if (!resetn) begin
      m_st = M_DA; m_addr = 0;
    end else if (m_st != M_DA && sr[m_addr]) begin
      m_st = M_DA;
    end else begin
      case (m_st)
        M_DA:  if (bus.pkt_valid && din != 3) begin
                 m_addr = din;
                 m_st   = empty[din] ? M_LFD : M_WTE;
               end
        M_WTE: if (empty[m_addr]) m_st = M_LFD;
        M_LFD: m_st = M_LD;
        M_LD:  if (bus.fifo_full) m_st = M_FF;
               else if (!bus.pkt_valid) m_st = M_LP;
        M_FF:  if (!bus.fifo_full) m_st = M_LAF;
        M_LAF: m_st = bus.parity_done ? M_DA : (bus.low_pkt_valid ? M_LP : M_LD);
        M_LP:  m_st = M_CPE;
        M_CPE: m_st = bus.fifo_full ? M_FF : M_DA;
        default: m_st = M_DA;
      endcase
    end
  endtask

  // Called just after a falling edge with inputs applied; returns on the next falling edge.
  task automatic tick();
    logic [1:0] a;
    model_step();
    a = m_addr[1:0];
    @(posedge clk);
    exp_q.push_back({flags_of(m_st), a});
    @(negedge clk);
  endtask

  task automatic set_idle();
    resetn            = 1'b1;
    bus.pkt_valid     = 1'b0;
    bus.data_in       = 2'b00;
    bus.fifo_full     = 1'b0;
    bus.fifo_empty_0  = 1'b1;
    bus.fifo_empty_1  = 1'b1;
    bus.fifo_empty_2  = 1'b1;
    bus.soft_reset_0  = 1'b0;
    bus.soft_reset_1  = 1'b0;
    bus.soft_reset_2  = 1'b0;
    bus.parity_done   = 1'b0;
    bus.low_pkt_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    logic [9:0] act;
    cyc++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
             bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy,
             bus.addr_out};
      checks++;
      if (act !== e) begin
        fails++;
        $display("FAIL outputs cycle %0d: got %b required %b (state_dbg=%0d)",
                 cyc, act, e, bus.state_dbg);
      end
    end
  end

  initial begin
    checks = 0; fails = 0; cyc = 0;
    m_st = M_DA; m_addr = 0;
    set_idle();
    resetn = 1'b0;
    @(negedge clk);
    // Reset state
    tick(); tick();
    resetn = 1'b1;

    // Normal packet to port 1
    bus.pkt_valid = 1'b1; bus.data_in = 2'b01;
    tick(); tick(); tick();
    bus.pkt_valid = 1'b0;
    tick(); tick(); tick();

    // Invalid address held for 4 cycles
    bus.pkt_valid = 1'b1; bus.data_in = 2'b11;
    repeat (4) tick();
    bus.pkt_valid = 1'b0;

    // Busy destination port 2
    bus.pkt_valid = 1'b1; bus.data_in = 2'b10; bus.fifo_empty_2 = 1'b0;
    repeat (5) tick();
    bus.fifo_empty_2 = 1'b1;
    tick(); tick();
    bus.pkt_valid = 1'b0;
    repeat (3) tick();

    // FIFO full mid-payload, released with low_pkt_valid
    bus.pkt_valid = 1'b1; bus.data_in = 2'b00;
    tick(); tick();
    bus.fifo_full = 1'b1;
    repeat (3) tick();
    bus.fifo_full = 1'b0; bus.low_pkt_valid = 1'b1;
    tick(); tick();
    bus.low_pkt_valid = 1'b0; bus.pkt_valid = 1'b0;
    tick(); tick();

    // Soft reset: foreign port ignored, own port aborts
    bus.pkt_valid = 1'b1; bus.data_in = 2'b00;
    tick(); tick();
    bus.soft_reset_1 = 1'b1;
    tick();
    bus.soft_reset_1 = 1'b0; bus.soft_reset_0 = 1'b1;
    tick();
    bus.soft_reset_0 = 1'b0; bus.pkt_valid = 1'b0;
    tick();

    // Reset while stalled on a full FIFO
    bus.pkt_valid = 1'b1; bus.data_in = 2'b10;
    tick(); tick();
    bus.fifo_full = 1'b1;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1; bus.fifo_full = 1'b0; bus.pkt_valid = 1'b0;
    tick(); tick();

    // Random traffic
    repeat (2000) begin
      resetn            = ($urandom_range(0, 99) < 98);
      bus.pkt_valid     = ($urandom_range(0, 99) < 80);
      bus.data_in       = 2'($urandom_range(0, 3));
      bus.fifo_full     = ($urandom_range(0, 99) < 20);
      bus.fifo_empty_0  = ($urandom_range(0, 99) < 70);
      bus.fifo_empty_1  = ($urandom_range(0, 99) < 70);
      bus.fifo_empty_2  = ($urandom_range(0, 99) < 70);
      bus.soft_reset_0  = ($urandom_range(0, 99) < 3);
      bus.soft_reset_1  = ($urandom_range(0, 99) < 3);
      bus.soft_reset_2  = ($urandom_range(0, 99) < 3);
      bus.parity_done   = ($urandom_range(0, 99) < 10);
      bus.low_pkt_valid = ($urandom_range(0, 99) < 20);
      tick();
    end
    set_idle();

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
